// File: rtl/fft_stage_ctrl_pkg.sv
// Shared encodings for the 2048-point FFT stage sequencer: stage modes,
// radix-4 stage codes, stage lengths, FSM states and issue-word packing.
package fft_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_GAP   = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_R4   = 2'b10;
    localparam logic [1:0] MODE_R2F  = 2'b11;

    localparam logic [2:0] ST1 = 3'b100;
    localparam logic [2:0] ST2 = 3'b101;
    localparam logic [2:0] ST3 = 3'b110;
    localparam logic [2:0] ST4 = 3'b111;
    localparam logic [2:0] ST5 = 3'b000;

    localparam int unsigned R4_LEN = 32'd256;
    localparam int unsigned R2_LEN = 32'd1024;

    // Stages are numbered 1..6; stage 6 is the radix-2 stage with factor.
    localparam logic [2:0] FIRST_STAGE = 3'd1;
    localparam logic [2:0] LAST_STAGE  = 3'd6;

    function automatic logic [2:0] stage_code(input logic [2:0] stage);
        logic [2:0] code;
        case (stage)
            3'd1:    code = ST1;
            3'd2:    code = ST2;
            3'd3:    code = ST3;
            3'd4:    code = ST4;
            3'd5:    code = ST5;
            default: code = ST5;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] stage_mode(input logic [2:0] stage);
        logic [1:0] m;
        if (stage == LAST_STAGE) begin
            m = MODE_R2F;
        end else begin
            m = MODE_R4;
        end
        return m;
    endfunction

    function automatic logic [9:0] last_index(input logic [2:0] stage);
        logic [9:0] li;
        if (stage == LAST_STAGE) begin
            li = 10'(R2_LEN - 32'd1);
        end else begin
            li = 10'(R4_LEN - 32'd1);
        end
        return li;
    endfunction

    // Radix-2 words carry the full 10-bit index; radix-4 words carry the stage code.
    function automatic logic [11:0] issue_word(input logic [2:0] stage, input logic [9:0] idx);
        logic [11:0] w;
        if (stage == LAST_STAGE) begin
            w = {2'b10, idx};
        end else begin
            w = {1'b0, stage_code(stage), idx[7:0]};
        end
        return w;
    endfunction

endpackage

// File: rtl/fft_stage_ctrl.sv
// Sequences the six butterfly stages of a 2048-point transform, emitting one
// registered issue word per non-stalled cycle with idle gaps between stages.
module fft_stage_ctrl
    import fft_stage_ctrl_pkg::*;
#(
    parameter int unsigned GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    output logic [11:0] cnt,
    output logic        ready,
    output logic [1:0]  mode,
    output logic        busy,
    output logic        done
);

    localparam bit         GAP_NONE = (GAP == 32'd0);
    localparam logic [3:0] GAP_LAST = GAP_NONE ? 4'd0 : 4'(GAP - 32'd1);

    state_e      state_q, state_d;
    logic [2:0]  stage_q, stage_d;
    logic [9:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [11:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic [1:0]  mode_q, mode_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        armed_q, armed_d;

    // Next-state and next-output logic for the stage sequencer.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        // armed_q blocks a start that lands on the reset release edge
        armed_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start && armed_q) begin
                    state_d = S_ISSUE;
                    stage_d = FIRST_STAGE;
                    idx_d   = 10'd0;
                    gap_d   = 4'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ISSUE: begin
                if (!stall) begin
                    ready_d = 1'b1;
                    cnt_d   = issue_word(stage_q, idx_q);
                    mode_d  = stage_mode(stage_q);
                    if (idx_q == last_index(stage_q)) begin
                        idx_d = 10'd0;
                        if (stage_q == LAST_STAGE) begin
                            state_d = S_DONE;
                        end else if (GAP_NONE) begin
                            stage_d = stage_q + 3'd1;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = 4'd0;
                        end
                    end else begin
                        idx_d = idx_q + 10'd1;
                    end
                end else begin
                    ready_d = 1'b0;
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_ISSUE;
                    stage_d = stage_q + 3'd1;
                    gap_d   = 4'd0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                stage_d = 3'd0;
                idx_d   = 10'd0;
                cnt_d   = 12'd0;
                mode_d  = MODE_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
                stage_d = 3'd0;
                idx_d   = 10'd0;
                gap_d   = 4'd0;
                cnt_d   = 12'd0;
                mode_d  = MODE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= 3'd0;
            idx_q   <= 10'd0;
            gap_q   <= 4'd0;
            cnt_q   <= 12'd0;
            ready_q <= 1'b0;
            mode_q  <= MODE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            armed_q <= armed_d;
        end
    end

    assign cnt   = cnt_q;
    assign ready = ready_q;
    assign mode  = mode_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: GAP=4 and GAP=0 instances share stimulus and are
// compared every cycle against an issue-count based reference model.
module tb_fft_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;

    logic [11:0] cnt4, cnt0;
    logic        ready4, ready0, busy4, busy0, done4, done0;
    logic [1:0]  mode4, mode0;

    fft_stage_ctrl #(.GAP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .cnt(cnt4), .ready(ready4), .mode(mode4), .busy(busy4), .done(done4)
    );

    fft_stage_ctrl #(.GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .cnt(cnt0), .ready(ready0), .mode(mode0), .busy(busy0), .done(done0)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the number of issues made; everything else is derived.
    int          gaps [2] = '{4, 0};
    bit          m_active [2];
    bit          m_fin [2];
    int          m_k [2];
    int          m_gap [2];
    bit          m_armed = 1'b0;
    logic [11:0] e_cnt [2];
    logic        e_ready [2];
    logic [1:0]  e_mode [2];
    logic        e_busy [2];
    logic        e_done [2];
    logic        in_start, in_stall, in_rst;

    function automatic logic [11:0] word_of(input int k);
        int s;
        int code;
        if (k < 1280) begin
            s = k / 256;
            code = (s < 4) ? (4 + s) : 0;
            return 12'(code * 256 + k % 256);
        end
        return 12'(2048 + (k - 1280));
    endfunction

    task automatic model_step(input int i);
        if (!in_rst) begin
            m_active[i] = 1'b0; m_fin[i] = 1'b0; m_k[i] = 0; m_gap[i] = 0;
            e_cnt[i] = 12'd0; e_ready[i] = 1'b0; e_mode[i] = 2'b00;
            e_busy[i] = 1'b0; e_done[i] = 1'b0;
        end else begin
            e_ready[i] = 1'b0;
            e_done[i]  = 1'b0;
            if (m_fin[i]) begin
                e_done[i] = 1'b1; e_busy[i] = 1'b0; e_mode[i] = 2'b00; e_cnt[i] = 12'd0;
                m_fin[i] = 1'b0; m_active[i] = 1'b0;
            end else if (!m_active[i]) begin
                if (in_start && m_armed) begin
                    m_active[i] = 1'b1; m_k[i] = 0; m_gap[i] = 0; e_busy[i] = 1'b1;
                end
            end else if (m_gap[i] > 0) begin
                m_gap[i]--;
            end else if (!in_stall) begin
                e_ready[i] = 1'b1;
                e_cnt[i]   = word_of(m_k[i]);
                e_mode[i]  = (m_k[i] < 1280) ? 2'b10 : 2'b11;
                m_k[i]++;
                if (m_k[i] == 2304) m_fin[i] = 1'b1;
                else if (m_k[i] % 256 == 0 && m_k[i] <= 1280) m_gap[i] = gaps[i];
            end
        end
    endtask

    // Per-run bookkeeping gathered by the compare process.
    int          n_rdy4 = 0, n_rdy0 = 0, n_done4 = 0, n_done0 = 0;
    time         t_edge, t_start, t_done4, t_done0;
    logic [13:0] seq4 [$];

    initial begin
        forever begin
            @(posedge clk);
            t_edge   = $time;
            in_start = start;
            in_stall = stall;
            in_rst   = rst_n;
            model_step(0);
            model_step(1);
            m_armed = in_rst;
            #2;
            chk("outputs_gap4", {15'd0, cnt4, ready4, mode4, busy4, done4},
                {15'd0, e_cnt[0], e_ready[0], e_mode[0], e_busy[0], e_done[0]});
            chk("outputs_gap0", {15'd0, cnt0, ready0, mode0, busy0, done0},
                {15'd0, e_cnt[1], e_ready[1], e_mode[1], e_busy[1], e_done[1]});
            if (ready4) begin n_rdy4++; seq4.push_back({mode4, cnt4}); end
            if (ready0) n_rdy0++;
            if (done4) begin n_done4++; t_done4 = t_edge; end
            if (done0) begin n_done0++; t_done0 = t_edge; end
        end
    end

    task automatic clear_run();
        n_rdy4 = 0; n_rdy0 = 0; n_done4 = 0; n_done0 = 0;
        seq4.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        t_start = $time;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cnt4(input logic [11:0] v, input bit rnd, input int bound);
        int c = 0;
        bit found = 1'b0;
        while (!found && c < bound) begin
            @(negedge clk);
            c++;
            if (ready4 && cnt4 == v) found = 1'b1;
            else stall = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        stall = 1'b0;
        chk("cnt_reached_in_bound", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_done(input bit rnd, input int bound);
        int c = 0;
        while ((n_done4 == 0 || n_done0 == 0) && c < bound) begin
            @(negedge clk);
            c++;
            stall = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        stall = 1'b0;
        chk("done_within_bound", {31'd0, (c < bound)}, 32'd1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_run_totals();
        chk("issues_gap4", n_rdy4, 32'd2304);
        chk("issues_gap0", n_rdy0, 32'd2304);
        chk("done_pulses_gap4", n_done4, 32'd1);
        chk("done_pulses_gap0", n_done0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk("reset_outputs_gap4", {15'd0, cnt4, ready4, mode4, busy4, done4}, 32'd0);
        chk("reset_outputs_gap0", {15'd0, cnt0, ready0, mode0, busy0, done0}, 32'd0);

        // Release reset with start already high: that start must be ignored.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("start_at_release_ignored", {31'd0, busy4}, 32'd0);

        // Run A: no stall, check timing and stage-boundary words.
        clear_run();
        pulse_start();
        wait_done(1'b0, 3000);
        check_run_totals();
        chk("done_cycle_gap4", 32'((t_done4 - t_start) / 10), 32'd2325);
        chk("done_cycle_gap0", 32'((t_done0 - t_start) / 10), 32'd2305);
        if (seq4.size() == 2304) begin
            chk("first_issue",  {18'd0, seq4[0]},    {18'd0, 2'b10, 12'h400});
            chk("st1_last",     {18'd0, seq4[255]},  {18'd0, 2'b10, 12'h4FF});
            chk("st2_first",    {18'd0, seq4[256]},  {18'd0, 2'b10, 12'h500});
            chk("st5_last",     {18'd0, seq4[1279]}, {18'd0, 2'b10, 12'h0FF});
            chk("r2_first",     {18'd0, seq4[1280]}, {18'd0, 2'b11, 12'h800});
            chk("final_issue",  {18'd0, seq4[2303]}, {18'd0, 2'b11, 12'hBFF});
        end else begin
            chk("issue_sequence_length", seq4.size(), 32'd2304);
        end

        // Run B: second start in ST2, 3-cycle stall at ST3 index 100, then random stall.
        clear_run();
        pulse_start();
        wait_cnt4(12'h540, 1'b0, 1000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cnt4(12'h663, 1'b0, 1000);
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_ready_low", {31'd0, ready4}, 32'd0);
            chk("stall_cnt_held", {20'd0, cnt4}, {20'd0, 12'h663});
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stall_resume", {19'd0, ready4, cnt4}, {19'd0, 1'b1, 12'h664});
        wait_done(1'b1, 5000);
        check_run_totals();

        // Run C: abort in ST4 with reset, then restart from stage 1.
        clear_run();
        pulse_start();
        wait_cnt4(12'h750, 1'b1, 5000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_gap4", {15'd0, cnt4, ready4, mode4, busy4, done4}, 32'd0);
        chk("abort_outputs_gap0", {15'd0, cnt0, ready0, mode0, busy0, done0}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done_gap4", n_done4, 32'd0);
        chk("abort_no_done_gap0", n_done0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        clear_run();
        pulse_start();
        wait_done(1'b1, 5000);
        check_run_totals();
        if (seq4.size() > 0) begin
            chk("restart_first_issue", {18'd0, seq4[0]}, {18'd0, 2'b10, 12'h400});
        end else begin
            chk("restart_issue_count", seq4.size(), 32'd2304);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
